// File: rtl/ge_seq_ctrl_pkg.sv
// Shared definitions for the Gaussian-eliminator sequencer: FSM encoding and
// address-width helper.
package ge_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT_TRI,
        ST_SYS_START,
        ST_WAIT_SYS,
        ST_DRAIN,
        ST_FIN
    } state_e;

    // A single-row store still needs a one-bit address port.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ge_edge_det.sv
// Registered rising-edge detector. A level that is already high when the
// consumer starts looking never produces a pulse.
module ge_edge_det (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic rise
);

    logic d_q, d_d;

    always_comb d_d = d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) d_q <= 1'b0;
        else        d_q <= d_d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/ge_seq_ctrl.sv
// Sequencer for the combined systolic Gaussian eliminator: loads rows, runs the
// triangularize and systemize passes, writes results back in descending order.
module ge_seq_ctrl
    import ge_seq_ctrl_pkg::*;
#(
    parameter int DAT_W = 80,
    parameter int DAT_D = 80,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       go,
    output logic                       busy,
    output logic                       done,
    output logic                       full_rank,
    output logic [CNT_W-1:0]           cycles,
    output logic [addr_w(DAT_D)-1:0]   rd_addr,
    output logic                       rd_en,
    input  logic [DAT_W-1:0]           rd_q,
    output logic [addr_w(DAT_D)-1:0]   wr_addr,
    output logic                       wr_en,
    output logic [DAT_W-1:0]           wr_data,
    output logic                       sa_start,
    output logic                       sa_mode,
    output logic [DAT_W-1:0]           sa_data,
    input  logic                       sa_finish,
    input  logic                       sa_full_rank,
    input  logic [DAT_W-1:0]           sa_result
);

    localparam int             AW   = addr_w(DAT_D);
    localparam logic [AW-1:0]  LAST = AW'(DAT_D - 1);

    state_e              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [DAT_W-1:0]    res_q, res_d;
    logic                fr_q, fr_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic                fin_rise;

    ge_edge_det u_fin_edge (
        .clk  (clk),
        .rst_b(rst_b),
        .d    (sa_finish),
        .rise (fin_rise)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        res_d    = res_q;
        fr_d     = fr_q;
        cyc_d    = cyc_q;
        rd_en    = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        sa_start = 1'b0;
        sa_mode  = 1'b0;
        sa_data  = '0;
        done     = 1'b0;

        if (state_q != ST_IDLE && cyc_q != '1) cyc_d = cyc_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_FETCH;
                    cyc_d   = '0;
                end
            end
            ST_FETCH: begin
                rd_en   = 1'b1;
                idx_d   = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Row j arrives on rd_q this cycle; prefetch row j+1 alongside.
                sa_data  = rd_q;
                sa_start = (idx_q == '0);
                if (idx_q != LAST) begin
                    rd_en   = 1'b1;
                    rd_addr = idx_q + 1'b1;
                    idx_d   = idx_q + 1'b1;
                end else begin
                    state_d = ST_WAIT_TRI;
                end
            end
            ST_WAIT_TRI: begin
                if (fin_rise) begin
                    fr_d    = sa_full_rank;
                    state_d = sa_full_rank ? ST_SYS_START : ST_FIN;
                end
            end
            ST_SYS_START: begin
                sa_mode  = 1'b1;
                sa_start = 1'b1;
                state_d  = ST_WAIT_SYS;
            end
            ST_WAIT_SYS: begin
                sa_mode = 1'b1;
                if (fin_rise) begin
                    res_d   = sa_result;
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Write the row captured last cycle while capturing the next one.
                sa_mode = 1'b1;
                wr_en   = 1'b1;
                wr_addr = LAST - idx_q;
                if (idx_q != LAST) begin
                    res_d = sa_result;
                    idx_d = idx_q + 1'b1;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            res_q   <= '0;
            fr_q    <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            fr_q    <= fr_d;
            cyc_q   <= cyc_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign full_rank = fr_q;
    assign cycles    = cyc_q;
    assign wr_data   = res_q;

endmodule

// File: tb/tb_ge_seq_ctrl.sv
// Self-checking bench: cycle-indexed timeline model of a run, driven by a
// scripted array stub with randomized rows, results and latencies.
module tb_ge_seq_ctrl;
    import ge_seq_ctrl_pkg::*;

    localparam int DD  = 4;
    localparam int DW  = 8;
    localparam int CW  = 32;
    localparam int AW  = addr_w(DD);
    localparam int CW1 = 4;
    localparam int AW1 = addr_w(1);

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // main instance
    logic          go = 1'b0, busy, done, full_rank;
    logic [CW-1:0] cycles;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          rd_en, wr_en, sa_start, sa_mode;
    logic [DW-1:0] rd_q = '0, wr_data, sa_data, sa_result = '0;
    logic          sa_finish = 1'b0, sa_full_rank = 1'b0;
    logic [DW-1:0] mem [DD];
    logic [DW-1:0] res [DD];

    always @(posedge clk) if (rd_en) rd_q <= mem[rd_addr];

    ge_seq_ctrl #(.DAT_W(DW), .DAT_D(DD), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_b(rst_b), .go(go), .busy(busy), .done(done),
        .full_rank(full_rank), .cycles(cycles),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_q(rd_q),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
        .sa_start(sa_start), .sa_mode(sa_mode), .sa_data(sa_data),
        .sa_finish(sa_finish), .sa_full_rank(sa_full_rank), .sa_result(sa_result)
    );

    // single-row instance with a narrow runtime counter
    logic           go1 = 1'b0, busy1, done1, full_rank1;
    logic [CW1-1:0] cycles1;
    logic [AW1-1:0] rd_addr1, wr_addr1;
    logic           rd_en1, wr_en1, sa_start1, sa_mode1;
    logic [DW-1:0]  rd_q1 = '0, wr_data1, sa_data1, sa_result1 = '0;
    logic           sa_finish1 = 1'b0, sa_full_rank1 = 1'b0;
    logic [DW-1:0]  mem1;

    always @(posedge clk) if (rd_en1) rd_q1 <= mem1;

    ge_seq_ctrl #(.DAT_W(DW), .DAT_D(1), .CNT_W(CW1)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .go(go1), .busy(busy1), .done(done1),
        .full_rank(full_rank1), .cycles(cycles1),
        .rd_addr(rd_addr1), .rd_en(rd_en1), .rd_q(rd_q1),
        .wr_addr(wr_addr1), .wr_en(wr_en1), .wr_data(wr_data1),
        .sa_start(sa_start1), .sa_mode(sa_mode1), .sa_data(sa_data1),
        .sa_finish(sa_finish1), .sa_full_rank(sa_full_rank1), .sa_result(sa_result1)
    );

    // One run on the main instance. Cycle 0 presents go; the model derives every
    // expected output of cycle r from the event times of the run.
    task automatic run_case(input string nm, input bit rank, input int tri_lat,
                            input int hold_len, input int sys_lat, input bit spam,
                            input int rst_wr);
        int t_c, s_c, done_c, rst_at, cyc_e;
        logic [5:0] ctl_e, ctl;
        t_c    = DD + 1 + tri_lat;
        s_c    = t_c + hold_len + sys_lat;
        done_c = rank ? s_c + DD + 1 : t_c + 1;
        rst_at = (rank && rst_wr > 0) ? s_c + rst_wr : -1;
        @(posedge clk); #1;
        for (int r = 0; r <= done_c + 2; r++) begin
            go           = (r == 0) || (spam && r <= done_c);
            sa_finish    = (r >= t_c && r < t_c + hold_len) || (rank && r == s_c);
            sa_full_rank = sa_finish ? rank : 1'($urandom);
            sa_result    = (rank && r >= s_c && r < s_c + DD) ? res[r - s_c] : DW'($urandom);
            #1;
            ctl_e = {r >= 1 && r <= done_c, r == done_c, r >= 1 && r <= DD,
                     r == 2 || (rank && r == t_c + 1),
                     rank && r > t_c && r <= s_c + DD,
                     rank && r > s_c && r <= s_c + DD};
            ctl = {busy, done, rd_en, sa_start, sa_mode, wr_en};
            checks++;
            if (ctl !== ctl_e) begin
                errors++;
                $display("FAIL %s ctl{busy,done,rd_en,start,mode,wr_en} r=%0d got=%b exp=%b", nm, r, ctl, ctl_e);
            end
            if (ctl_e[3]) begin
                checks++;
                if (rd_addr !== AW'(r - 1)) begin
                    errors++;
                    $display("FAIL %s rd_addr r=%0d got=%0d exp=%0d", nm, r, rd_addr, r - 1);
                end
            end
            if (r >= 2 && r <= DD + 1) begin
                checks++;
                if (sa_data !== mem[r - 2]) begin
                    errors++;
                    $display("FAIL %s sa_data r=%0d got=%h exp=%h", nm, r, sa_data, mem[r - 2]);
                end
            end
            if (ctl_e[0]) begin
                checks++;
                if (wr_addr !== AW'(DD - 1 - (r - s_c - 1)) || wr_data !== res[r - s_c - 1]) begin
                    errors++;
                    $display("FAIL %s write r=%0d got=%0d/%h exp=%0d/%h", nm, r, wr_addr, wr_data,
                             DD - 1 - (r - s_c - 1), res[r - s_c - 1]);
                end
            end
            if (r > t_c && r != rst_at + 1) begin
                checks++;
                if (full_rank !== rank) begin
                    errors++;
                    $display("FAIL %s full_rank r=%0d got=%b exp=%b", nm, r, full_rank, rank);
                end
            end
            if (r >= 1) begin
                cyc_e = (r <= done_c) ? r - 1 : done_c;
                checks++;
                if (cycles !== CW'(cyc_e)) begin
                    errors++;
                    $display("FAIL %s cycles r=%0d got=%0d exp=%0d", nm, r, cycles, cyc_e);
                end
            end
            if (r == rst_at) begin
                go = 1'b0; sa_finish = 1'b0;
                rst_b = 1'b0; #1;
                checks++;
                if ({busy, done, full_rank, rd_en, wr_en, sa_start, sa_mode} !== 7'b0 ||
                    rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0 || cycles !== '0) begin
                    errors++;
                    $display("FAIL %s mid-run reset got ctl=%b wr_data=%h cycles=%0d exp all zero", nm,
                             {busy, done, full_rank, rd_en, wr_en, sa_start, sa_mode}, wr_data, cycles);
                end
                #2 rst_b = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        go = 1'b0; sa_finish = 1'b0;
    endtask

    task automatic load_random();
        foreach (mem[i]) mem[i] = DW'($urandom);
        foreach (res[i]) res[i] = DW'($urandom);
    endtask

    task automatic test_reset();
        #2 rst_b = 1'b0; #2;
        checks++;
        if ({busy, done, full_rank, rd_en, wr_en, sa_start, sa_mode} !== 7'b0 ||
            rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0 || cycles !== '0) begin
            errors++;
            $display("FAIL reset main got ctl=%b cycles=%0d exp all zero",
                     {busy, done, full_rank, rd_en, wr_en, sa_start, sa_mode}, cycles);
        end
        checks++;
        if ({busy1, done1, full_rank1, rd_en1, wr_en1, sa_start1, sa_mode1} !== 7'b0 ||
            wr_data1 !== '0 || cycles1 !== '0) begin
            errors++;
            $display("FAIL reset single got ctl=%b cycles=%0d exp all zero",
                     {busy1, done1, full_rank1, rd_en1, wr_en1, sa_start1, sa_mode1}, cycles1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_b = 1'b1;
    endtask

    task automatic test_basic();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
        res[0] = 8'h80; res[1] = 8'h40; res[2] = 8'h20; res[3] = 8'h10;
        run_case("basic", 1'b1, 5, 1, 5, 1'b0, 0);
    endtask

    task automatic test_rank_deficient();
        load_random();
        run_case("rank0", 1'b0, int'($urandom_range(1, 8)), 1, 3, 1'b0, 0);
        checks++;
        if (full_rank !== 1'b0) begin
            errors++;
            $display("FAIL rank0 held verdict got=%b exp=0", full_rank);
        end
    endtask

    task automatic test_random_runs();
        for (int k = 0; k < 5; k++) begin
            load_random();
            run_case("random", 1'b1, int'($urandom_range(1, 8)), 1, int'($urandom_range(1, 8)), 1'b0, 0);
        end
    endtask

    task automatic test_go_spam();
        load_random();
        run_case("go_spam", 1'b1, 3, 1, 4, 1'b1, 0);
    endtask

    task automatic test_finish_hold();
        load_random();
        run_case("finish_hold", 1'b1, 2, 4, 3, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        load_random();
        run_case("reset_mid", 1'b1, 2, 1, 2, 1'b0, 2);
        load_random();
        run_case("after_reset", 1'b1, 2, 1, 2, 1'b0, 0);
    endtask

    task automatic test_single_row();
        int t_c, s_c, done_c, cyc_e;
        logic [DW-1:0] r1;
        logic [4:0] ctl_e, ctl;
        mem1 = DW'($urandom);
        r1   = DW'($urandom);
        t_c = 2 + 20;
        s_c = t_c + 1 + 20;
        done_c = s_c + 2;
        @(posedge clk); #1;
        for (int r = 0; r <= done_c + 2; r++) begin
            go1           = (r == 0);
            sa_finish1    = (r == t_c) || (r == s_c);
            sa_full_rank1 = 1'b1;
            sa_result1    = (r == s_c) ? r1 : DW'($urandom);
            #1;
            ctl_e = {r >= 1 && r <= done_c, r == done_c, r == 1, r == 2 || r == t_c + 1, r == s_c + 1};
            ctl   = {busy1, done1, rd_en1, sa_start1, wr_en1};
            checks++;
            if (ctl !== ctl_e) begin
                errors++;
                $display("FAIL single ctl{busy,done,rd_en,start,wr_en} r=%0d got=%b exp=%b", r, ctl, ctl_e);
            end
            if (r == 2) begin
                checks++;
                if (sa_data1 !== mem1) begin
                    errors++;
                    $display("FAIL single sa_data got=%h exp=%h", sa_data1, mem1);
                end
            end
            if (r == s_c + 1) begin
                checks++;
                if (wr_addr1 !== '0 || wr_data1 !== r1) begin
                    errors++;
                    $display("FAIL single write got=%0d/%h exp=0/%h", wr_addr1, wr_data1, r1);
                end
            end
            if (r >= 1) begin
                cyc_e = (r <= done_c) ? r - 1 : done_c;
                if (cyc_e > 15) cyc_e = 15;
                checks++;
                if (cycles1 !== CW1'(cyc_e)) begin
                    errors++;
                    $display("FAIL single cycles r=%0d got=%0d exp=%0d", r, cycles1, cyc_e);
                end
            end
            @(posedge clk); #1;
        end
        go1 = 1'b0; sa_finish1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rank_deficient();
        test_random_runs();
        test_go_spam();
        test_finish_hold();
        test_reset_mid();
        test_single_row();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
